// File: rtl/types.sv
// ---------------------------------------------------------------------------
// types: NoC flit format shared by the flitizer and unpacker.    rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package types;

  localparam int WORD_W    = 32;
  localparam int FLIT_W    = 128;

  localparam int TYPE_OFF  = 126;
  localparam int TYPE_W    = 2;
  localparam int SRC_OFF   = 118;
  localparam int SRC_W     = 8;
  localparam int DST_OFF   = 110;
  localparam int DST_W     = 8;
  localparam int PID_OFF   = 102;
  localparam int PID_W     = 8;
  localparam int FNUM_OFF  = 98;
  localparam int FNUM_W    = 4;
  localparam int CNT_OFF   = 96;
  localparam int CNT_W     = 2;
  localparam int PAY_OFF   = 0;
  localparam int PAY_W     = 96;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e          ftype;
    logic [SRC_W-1:0]    src_id;
    logic [DST_W-1:0]    dst_id;
    logic [PID_W-1:0]    packet_id;
    logic [FNUM_W-1:0]   flit_num;
    logic [CNT_W-1:0]    word_cnt;
    logic [PAY_W-1:0]    payload;
  } flit_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HDR   = 2'd1,
    ST_WORDS = 2'd2
  } unpack_state_e;

  // Zero gap is 8 bits so the word stays 32 bits with src/pid in the top bytes.
  function automatic logic [WORD_W-1:0] make_header_word(
    input logic [SRC_W-1:0]  src_id,
    input logic [PID_W-1:0]  packet_id,
    input logic [FNUM_W-1:0] flit_num
  );
    return {src_id, packet_id, 8'h00, flit_num, 4'h0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/flit_seq_checker.sv
// ---------------------------------------------------------------------------
// flit_seq_checker: packet framing / flit sequence tracker.       rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flit_seq_checker
  import types::*;
(
  input  logic              nocclk,
  input  logic              rst_n,
  input  logic              accept,
  input  flit_type_e        flit_type,
  input  logic [PID_W-1:0]  packet_id,
  input  logic [FNUM_W-1:0] flit_num,
  output logic              drop,
  output logic              seq_error,
  output logic              orphan_error
);

  logic              pkt_open;
  logic [PID_W-1:0]  open_pid;
  logic [FNUM_W-1:0] exp_fnum;
  logic              is_start;

  assign is_start = (flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE);
  assign drop     = !is_start && !pkt_open;

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_open     <= 1'b0;
      open_pid     <= '0;
      exp_fnum     <= '0;
      seq_error    <= 1'b0;
      orphan_error <= 1'b0;
    end else begin
      seq_error    <= 1'b0;
      orphan_error <= 1'b0;
      if (accept) begin
        if (is_start) begin
          // A start while open abandons the previous packet.
          seq_error <= pkt_open;
          pkt_open  <= (flit_type == FLIT_HEAD);
          open_pid  <= packet_id;
          exp_fnum  <= flit_num + 4'd1;
        end else if (!pkt_open) begin
          orphan_error <= 1'b1;
        end else begin
          seq_error <= (packet_id != open_pid) || (flit_num != exp_fnum);
          exp_fnum  <= exp_fnum + 4'd1;
          if (flit_type == FLIT_TAIL) begin
            pkt_open <= 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/noc_to_cpu_unpacker.sv
// ---------------------------------------------------------------------------
// noc_to_cpu_unpacker: 128-bit flits to 32-bit CPU words.         rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module noc_to_cpu_unpacker
  import types::*;
#(
  parameter int WORDS_PER_FLIT = 3
) (
  input  logic              nocclk,
  input  logic              rst_n,
  input  flit_t             poped_flit,
  input  logic              poped_flit_valid,
  output logic              poped_flit_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              data_out_last,
  input  logic              data_out_ready,
  output logic              seq_error,
  output logic              orphan_error
);

  localparam int PAYLOAD_W = WORDS_PER_FLIT * WORD_W;

  unpack_state_e          state;
  logic [PAYLOAD_W-1:0]   held_payload;
  logic [CNT_W-1:0]       held_n;
  logic                   held_close;
  logic [CNT_W-1:0]       word_idx;
  logic [CNT_W-1:0]       next_idx;

  logic                   accept;
  logic                   drop;
  logic                   word_done;
  logic                   final_word;
  logic                   in_start;
  logic                   in_close;
  logic [CNT_W-1:0]       in_n;
  logic [PAYLOAD_W-1:0]   in_payload;
  logic [WORD_W-1:0]      held_words [WORDS_PER_FLIT];
  logic [WORD_W-1:0]      in_words   [WORDS_PER_FLIT];
  logic                   unused_dst;

  assign unused_dst = ^poped_flit.dst_id;

  for (genvar i = 0; i < WORDS_PER_FLIT; i++) begin : g_words
    assign held_words[i] = held_payload[i*WORD_W +: WORD_W];
    assign in_words[i]   = in_payload[i*WORD_W +: WORD_W];
  end

  assign in_start   = (poped_flit.ftype == FLIT_HEAD) || (poped_flit.ftype == FLIT_SINGLE);
  assign in_close   = (poped_flit.ftype == FLIT_TAIL) || (poped_flit.ftype == FLIT_SINGLE);
  // An empty closing flit still emits one zero word so the packet terminates.
  assign in_n       = (poped_flit.word_cnt == '0) ? {1'b0, in_close} : poped_flit.word_cnt;
  assign in_payload = (poped_flit.word_cnt == '0) ? '0 : poped_flit.payload;

  assign word_done  = data_out_valid && data_out_ready;
  assign final_word = ((state == ST_HDR) && (held_n == '0)) ||
                      ((state == ST_WORDS) && (word_idx == held_n - 2'd1));
  assign poped_flit_ready = (state == ST_EMPTY) || (final_word && data_out_ready);
  assign accept     = poped_flit_valid && poped_flit_ready;
  assign next_idx   = word_idx + 2'd1;

  flit_seq_checker u_seq (
    .nocclk       (nocclk),
    .rst_n        (rst_n),
    .accept       (accept),
    .flit_type    (poped_flit.ftype),
    .packet_id    (poped_flit.packet_id),
    .flit_num     (poped_flit.flit_num),
    .drop         (drop),
    .seq_error    (seq_error),
    .orphan_error (orphan_error)
  );

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_EMPTY;
      held_payload   <= '0;
      held_n         <= '0;
      held_close     <= 1'b0;
      word_idx       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
    end else if (accept && !drop) begin
      held_payload <= in_payload;
      held_n       <= in_n;
      held_close   <= in_close;
      word_idx     <= '0;
      if (in_start) begin
        state          <= ST_HDR;
        data_out       <= make_header_word(poped_flit.src_id, poped_flit.packet_id,
                                           poped_flit.flit_num);
        data_out_valid <= 1'b1;
        data_out_last  <= 1'b0;
      end else if (in_n == '0) begin
        state          <= ST_EMPTY;
        data_out       <= '0;
        data_out_valid <= 1'b0;
        data_out_last  <= 1'b0;
      end else begin
        state          <= ST_WORDS;
        data_out       <= in_words[0];
        data_out_valid <= 1'b1;
        data_out_last  <= in_close && (in_n == 2'd1);
      end
    end else if (word_done) begin
      if (final_word) begin
        state          <= ST_EMPTY;
        data_out       <= '0;
        data_out_valid <= 1'b0;
        data_out_last  <= 1'b0;
      end else if (state == ST_HDR) begin
        state          <= ST_WORDS;
        word_idx       <= '0;
        data_out       <= held_words[0];
        data_out_last  <= held_close && (held_n == 2'd1);
      end else begin
        word_idx       <= next_idx;
        data_out       <= held_words[next_idx];
        data_out_last  <= held_close && (next_idx == held_n - 2'd1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_noc_to_cpu_unpacker.sv
// Scoreboard bench for noc_to_cpu_unpacker: directed packets plus random traffic.
`timescale 1ns/1ps
`default_nettype none

module tb_noc_to_cpu_unpacker;
  import types::*;

  localparam int MODE_ONE    = 0;
  localparam int MODE_TOGGLE = 1;
  localparam int MODE_RAND   = 2;
  localparam int MODE_MANUAL = 3;

  logic        nocclk = 1'b0;
  logic        rst_n  = 1'b0;
  flit_t       poped_flit = '0;
  logic        poped_flit_valid = 1'b0;
  logic        poped_flit_ready;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        data_out_last;
  logic        data_out_ready = 1'b0;
  logic        seq_error;
  logic        orphan_error;

  noc_to_cpu_unpacker #(.WORDS_PER_FLIT(3)) dut (
    .nocclk           (nocclk),
    .rst_n            (rst_n),
    .poped_flit       (poped_flit),
    .poped_flit_valid (poped_flit_valid),
    .poped_flit_ready (poped_flit_ready),
    .data_out         (data_out),
    .data_out_valid   (data_out_valid),
    .data_out_last    (data_out_last),
    .data_out_ready   (data_out_ready),
    .seq_error        (seq_error),
    .orphan_error     (orphan_error)
  );

  always #5 nocclk = ~nocclk;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          mode  = MODE_ONE;

  bit          m_open;
  logic [7:0]  m_pid;
  logic [3:0]  m_fnum;
  bit          exp_seq;
  bit          exp_orph;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a flit means at packet level, independent of DUT sequencing.
  task automatic model_flit(input flit_t f);
    int n;
    bit close;
    close = (f.ftype == FLIT_TAIL) || (f.ftype == FLIT_SINGLE);
    if (f.ftype == FLIT_HEAD || f.ftype == FLIT_SINGLE) begin
      exp_seq = m_open;
      m_open  = (f.ftype == FLIT_HEAD);
      m_pid   = f.packet_id;
      m_fnum  = f.flit_num + 4'd1;
      sb.push_back('{{f.src_id, f.packet_id, 8'h00, f.flit_num, 4'h0}, 1'b0});
    end else if (!m_open) begin
      exp_orph = 1'b1;
      return;
    end else begin
      exp_seq = (f.packet_id != m_pid) || (f.flit_num != m_fnum);
      m_fnum  = m_fnum + 4'd1;
      if (f.ftype == FLIT_TAIL) m_open = 1'b0;
    end
    n = int'(f.word_cnt);
    for (int i = 0; i < n; i++)
      sb.push_back('{f.payload[32*i +: 32], close && (i == n - 1)});
    if (n == 0 && close) sb.push_back('{32'h0, 1'b1});
  endtask

  always @(negedge nocclk) begin
    case (mode)
      MODE_ONE:    data_out_ready = 1'b1;
      MODE_TOGGLE: data_out_ready = ~data_out_ready;
      MODE_RAND:   data_out_ready = ($urandom_range(0, 3) != 0);
      default:     ;
    endcase
  end

  logic        s_acc, s_dv, s_dr, s_last;
  logic [31:0] s_data;
  flit_t       s_flit;
  exp_t        e;

  always begin
    @(posedge nocclk);
    exp_seq  = 1'b0;
    exp_orph = 1'b0;
    if (rst_n) begin
      s_acc  = poped_flit_valid && poped_flit_ready;
      s_flit = poped_flit;
      s_dv   = data_out_valid;
      s_dr   = data_out_ready;
      s_data = data_out;
      s_last = data_out_last;
      if (s_acc) model_flit(s_flit);
      #1;
      if (s_dv && s_dr) begin
        if (sb.size() == 0) begin
          check("spurious_word_valid", 32'(s_dv), 32'd0);
        end else begin
          e = sb.pop_front();
          check("data_out", s_data, e.w);
          check("data_out_last", 32'(s_last), 32'(e.last));
        end
      end else if (s_dv) begin
        check("stall_valid", 32'(data_out_valid), 32'd1);
        check("stall_data", data_out, s_data);
        check("stall_last", 32'(data_out_last), 32'(s_last));
      end
      check("seq_error", 32'(seq_error), 32'(exp_seq));
      check("orphan_error", 32'(orphan_error), 32'(exp_orph));
    end
  end

  function automatic flit_t mk(input flit_type_e t, input logic [7:0] src, input logic [7:0] pid,
                               input logic [3:0] fnum, input logic [1:0] cnt);
    flit_t f;
    f.ftype     = t;
    f.src_id    = src;
    f.dst_id    = 8'($urandom);
    f.packet_id = pid;
    f.flit_num  = fnum;
    f.word_cnt  = cnt;
    f.payload   = {$urandom, $urandom, $urandom};
    return f;
  endfunction

  task automatic send(input flit_t f);
    poped_flit       = f;
    poped_flit_valid = 1'b1;
    for (int i = 0; ; i++) begin
      @(posedge nocclk);
      if (poped_flit_ready) break;
      if (i > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(negedge nocclk);
    poped_flit_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; ; i++) begin
      @(negedge nocclk);
      if (sb.size() == 0 && !data_out_valid) break;
      if (i > 500) begin
        check("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        break;
      end
    end
    repeat (2) @(negedge nocclk);
  endtask

  task automatic reset_dut();
    @(negedge nocclk);
    rst_n = 1'b0;
    sb.delete();
    m_open = 1'b0;
    repeat (2) @(negedge nocclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  flit_type_e gt;
  logic [7:0] g_pid;
  logic [3:0] g_fnum, fn;
  logic [7:0] pid;
  int         r;

  initial begin
    m_open = 1'b0;
    repeat (2) @(negedge nocclk);
    #1;
    check("rst_ready", 32'(poped_flit_ready), 32'd1);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_last", 32'(data_out_last), 32'd0);
    check("rst_seq", 32'(seq_error), 32'd0);
    check("rst_orphan", 32'(orphan_error), 32'd0);
    @(negedge nocclk);
    rst_n = 1'b1;

    // Single packet; header word checked against a literal too.
    mode = MODE_ONE;
    @(negedge nocclk);
    send(mk(FLIT_SINGLE, 8'h12, 8'h05, 4'h0, 2'd2));
    #1;
    check("single_header_literal", data_out, 32'h1205_0000);
    drain();

    // Three-flit packet with toggling backpressure.
    mode = MODE_TOGGLE;
    send(mk(FLIT_HEAD, 8'h33, 8'h07, 4'd0, 2'd0));
    send(mk(FLIT_BODY, 8'h33, 8'h07, 4'd1, 2'd3));
    send(mk(FLIT_TAIL, 8'h33, 8'h07, 4'd2, 2'd1));
    drain();

    // Orphan BODY after reset.
    mode = MODE_ONE;
    reset_dut();
    send(mk(FLIT_BODY, 8'h01, 8'h02, 4'd1, 2'd2));
    drain();

    // Sequence fault, then restart without TAIL, then a clean close.
    send(mk(FLIT_HEAD, 8'h44, 8'h09, 4'd0, 2'd1));
    send(mk(FLIT_BODY, 8'h44, 8'h09, 4'd3, 2'd2));
    send(mk(FLIT_HEAD, 8'h44, 8'h0A, 4'd0, 2'd0));
    send(mk(FLIT_TAIL, 8'h44, 8'h0A, 4'd1, 2'd2));
    drain();

    // Empty TAIL and empty BODY.
    send(mk(FLIT_HEAD, 8'h55, 8'h0B, 4'd0, 2'd0));
    send(mk(FLIT_BODY, 8'h55, 8'h0B, 4'd1, 2'd0));
    send(mk(FLIT_TAIL, 8'h55, 8'h0B, 4'd2, 2'd0));
    drain();

    // Reset while stalled in the middle of payload words.
    mode = MODE_MANUAL;
    data_out_ready = 1'b0;
    send(mk(FLIT_HEAD, 8'h66, 8'h0C, 4'd0, 2'd3));
    data_out_ready = 1'b1;
    @(negedge nocclk);
    @(negedge nocclk);
    data_out_ready = 1'b0;
    @(negedge nocclk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(poped_flit_ready), 32'd1);
    check("midrst_valid", 32'(data_out_valid), 32'd0);
    check("midrst_data", data_out, 32'd0);
    check("midrst_last", 32'(data_out_last), 32'd0);
    sb.delete();
    m_open = 1'b0;
    @(negedge nocclk);
    rst_n = 1'b1;
    mode = MODE_ONE;
    send(mk(FLIT_BODY, 8'h66, 8'h0C, 4'd1, 2'd1));
    drain();

    // Random traffic with occasional framing/sequence faults.
    mode   = MODE_RAND;
    g_pid  = 8'h00;
    g_fnum = 4'h0;
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 7);
      if (r < 2)      gt = FLIT_HEAD;
      else if (r < 3) gt = FLIT_SINGLE;
      else if (r < 6) gt = FLIT_BODY;
      else            gt = FLIT_TAIL;
      if (gt == FLIT_HEAD || gt == FLIT_SINGLE) begin
        g_pid  = 8'($urandom);
        g_fnum = 4'($urandom);
        pid    = g_pid;
        fn     = g_fnum;
      end else begin
        pid = ($urandom_range(0, 9) == 0) ? 8'($urandom) : g_pid;
        fn  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : g_fnum;
      end
      g_fnum = g_fnum + 4'd1;
      send(mk(gt, 8'($urandom), pid, fn, 2'($urandom)));
      if ($urandom_range(0, 5) == 0) @(negedge nocclk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
